// File: rtl/mysys_gpio_irq_if.sv
// Avalon-MM slave port bundle for the GPIO/IRQ peripheral (s1).
interface mysys_gpio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/mysys_gpio_irq.sv
// GPIO peripheral: per-bit direction, atomic set/clear, 2-flop input
// synchroniser, per-bit edge capture and a maskable level interrupt.

// One I/O bit: every register slice and the input path for that bit.
module mysys_gpio_irq_lane #(
  parameter int   EDGE_TYPE = 0,
  parameter logic RST_OUT   = 1'b0,
  parameter logic RST_DIR   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  input  logic wd,
  input  logic we_data,
  input  logic we_dir,
  input  logic we_mask,
  input  logic we_cap,
  input  logic we_set,
  input  logic we_clr,
  output logic out_bit,
  output logic oe_bit,
  output logic mask_bit,
  output logic cap_bit,
  output logic rd_bit
);
  logic sync1, sync2, sync3, edge_hit;

  // Two synchroniser flops plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_hit = sync2 & ~sync3;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_hit = ~sync2 & sync3;
    end else begin : g_any
      assign edge_hit = sync2 ^ sync3;
    end
  endgenerate

  // Output data: plain load, or atomic set/clear of bits written as 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               out_bit <= RST_OUT;
    else if (we_data)           out_bit <= wd;
    else if (we_set && wd)      out_bit <= 1'b1;
    else if (we_clr && wd)      out_bit <= 1'b0;
  end

  // Direction and interrupt mask are plain R/W bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oe_bit   <= RST_DIR;
      mask_bit <= 1'b0;
    end else begin
      if (we_dir)  oe_bit   <= wd;
      if (we_mask) mask_bit <= wd;
    end
  end

  // Edge capture with write-1-to-clear; a coincident edge beats the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cap_bit <= 1'b0;
    else          cap_bit <= (cap_bit & ~(we_cap & wd)) | edge_hit;
  end

  assign rd_bit = oe_bit ? out_bit : sync2;
endmodule

module mysys_gpio_irq #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] RESET_OUT = 32'h0,
  parameter logic [31:0] RESET_DIR = 32'h0,
  parameter int          EDGE_TYPE = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mysys_gpio_irq_if.slave      s1,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     out_en,
  output logic                 irq
);
  localparam logic [2:0] A_DATA = 3'd0, A_DIR = 3'd1, A_MASK = 3'd2,
                         A_CAP  = 3'd3, A_SET = 3'd4, A_CLR  = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] mask, cap, rd_vec;
  logic [31:0]      rdata;
  logic             unused_wd;

  assign wr = s1.chipselect & ~s1.write_n;
  // Bits of writedata at or above WIDTH are never routed to any lane
  assign unused_wd = ^s1.writedata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      mysys_gpio_irq_lane #(
        .EDGE_TYPE (EDGE_TYPE),
        .RST_OUT   (RESET_OUT[i]),
        .RST_DIR   (RESET_DIR[i])
      ) u_lane (
        .clk      (clk),
        .reset_n  (reset_n),
        .pin      (in_port[i]),
        .wd       (s1.writedata[i]),
        .we_data  (wr && s1.address == A_DATA),
        .we_dir   (wr && s1.address == A_DIR),
        .we_mask  (wr && s1.address == A_MASK),
        .we_cap   (wr && s1.address == A_CAP),
        .we_set   (wr && s1.address == A_SET),
        .we_clr   (wr && s1.address == A_CLR),
        .out_bit  (out_port[i]),
        .oe_bit   (out_en[i]),
        .mask_bit (mask[i]),
        .cap_bit  (cap[i]),
        .rd_bit   (rd_vec[i])
      );
    end
  endgenerate

  // Zero-latency read mux; write-only and reserved addresses read 0
  always_comb begin
    rdata = '0;
    case (s1.address)
      A_DATA:  rdata[WIDTH-1:0] = rd_vec;
      A_DIR:   rdata[WIDTH-1:0] = out_en;
      A_MASK:  rdata[WIDTH-1:0] = mask;
      A_CAP:   rdata[WIDTH-1:0] = cap;
      default: rdata = '0;
    endcase
  end

  assign s1.readdata = rdata;
  assign irq         = |(cap & mask);
endmodule
